// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned PC_W        = 32;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO holding fetched instructions tagged with their PC.
// Clear takes priority over push and pop; push on a full FIFO is legal only alongside a pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = fetch_entry_t,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  entry_t          push_data,
  input  logic            pop,
  input  logic            clear,
  output entry_t          head,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_pop;

  assign do_pop = pop && (count_q != '0);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (clear) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push)   wr_d = wr_q + 1'b1;
      if (do_pop) rd_d = rd_q + 1'b1;
      count_d = count_q + CntW'(push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (push && !clear) mem_q[wr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

  no_overflow_a: assert property (@(posedge clk) disable iff (!rst)
    (push && !do_pop && !clear) |-> (count_q != Full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word fetches and buffers responses.
// Optional FETCH_MISALIGN_EN halts on misaligned redirects and reports them.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
`ifdef FETCH_MISALIGN_EN
  ,
  output logic                  fetch_misalign,
  output logic [ADDR_WIDTH-1:0] misalign_pc
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW:0] DepthCnt = (CntW + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] Step = ADDR_WIDTH'(INSTR_BYTES);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target_pc;
  logic [CntW-1:0]       outstanding_q, outstanding_d, drop_q, drop_d, count;
  logic [CntW:0]         credit_used;
  logic                  req_fire, push, pop, clear;
  entry_t                push_entry, head;

`ifdef FETCH_MISALIGN_EN
  logic                  misalign_q, misalign_d;
  logic [ADDR_WIDTH-1:0] misalign_pc_q, misalign_pc_d;

  assign fetch_misalign = misalign_q;
  assign misalign_pc    = misalign_pc_q;
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

  assign target_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  // Credits cover both buffered entries and fetches still in flight, so the FIFO cannot overflow.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding_q};
  assign imem_req_valid = (state_q == RUN) && !redirect_valid && (credit_used < DepthCnt);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign instr_valid = count != '0;
  assign pop         = instr_valid && instr_ready;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign push_entry  = '{instr: imem_rsp_data, pc: rsp_pc_q};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    push          = 1'b0;
    clear         = 1'b0;
`ifdef FETCH_MISALIGN_EN
    misalign_d    = misalign_q;
    misalign_pc_d = misalign_pc_q;
`endif

    case (state_q)
      BOOT:    state_d = RUN;
      default: state_d = state_q;
    endcase

    if (req_fire) begin
      fetch_pc_d    = fetch_pc_q + Step;
      outstanding_d = outstanding_q + 1'b1;
    end
    if (imem_rsp_valid) outstanding_d = outstanding_d - 1'b1;

    if (redirect_valid) begin
      // Every fetch still in flight belongs to the old path; a response landing now is one of them.
      clear      = 1'b1;
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      drop_d     = outstanding_q - CntW'(imem_rsp_valid);
`ifdef FETCH_MISALIGN_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d       = HALT;
        misalign_d    = 1'b1;
        misalign_pc_d = redirect_pc;
      end else begin
        state_d    = RUN;
        misalign_d = 1'b0;
      end
`endif
    end else if (imem_rsp_valid) begin
      if (drop_q != '0) begin
        drop_d = drop_q - 1'b1;
      end else begin
        push     = 1'b1;
        rsp_pc_d = rsp_pc_q + Step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
`ifdef FETCH_MISALIGN_EN
      misalign_q    <= 1'b0;
      misalign_pc_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
`ifdef FETCH_MISALIGN_EN
      misalign_q    <= misalign_d;
      misalign_pc_q <= misalign_pc_d;
`endif
    end
  end

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .entry_t(entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .clear    (clear),
    .head     (head),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model plus an expected in-order PC stream for decode.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] XMASK = 32'hA5A5_0000;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, instr_valid, instr_ready;
  logic [31:0] redirect_pc, instr, instr_pc;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misalign;
  logic [31:0] misalign_pc;
`endif

  fetch_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .RESET_PC  (32'h0),
    .DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
`ifdef FETCH_MISALIGN_EN
    ,
    .fetch_misalign(fetch_misalign),
    .misalign_pc   (misalign_pc)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cycle    = 0;
  int          lat      = 1;
  bit          rand_ready = 1'b0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] exp_pc   = 32'h0;
  logic [31:0] last_pc  = 32'h0;
  int          pops     = 0;
  int          req_fires = 0;
  bit          expect_empty = 1'b0;
  bit          prev_pending = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: observe before the edge, then drive memory outputs just after it.
  task automatic tick();
    @(negedge clk);
    if (prev_pending && !redirect_valid) begin
      chk("req_hold_valid", imem_req_valid, 1);
      chk("req_hold_addr", imem_req_addr, prev_addr);
    end
    if (expect_empty) chk("flush_empty", instr_valid, 0);
    expect_empty = 1'b0;
    if (instr_valid && instr_ready) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr_data", instr, exp_pc ^ XMASK);
      last_pc = instr_pc;
      exp_pc  = exp_pc + 32'd4;
      pops++;
    end
    if (redirect_valid) begin
      exp_pc       = {redirect_pc[31:2], 2'b00};
      expect_empty = 1'b1;
    end
    if (imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cycle + lat);
      req_fires++;
    end
    prev_pending = imem_req_valid && !imem_req_ready;
    prev_addr    = imem_req_addr;
    @(posedge clk);
    #1;
    cycle++;
    if (mq_addr.size() != 0 && mq_due[0] <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq_addr.pop_front() ^ XMASK;
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    int goal;
    int k;
    goal = pops + n;
    k = 0;
    while (pops < goal && k < budget) begin
      tick();
      k++;
    end
    chk(tag, pops >= goal, 1);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int  base;
    bit  found;
    bit  any_req;

    rst = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    #2;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_MISALIGN_EN
    chk("rst_misalign", fetch_misalign, 0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("boot_no_req", imem_req_valid, 0);
    tick();
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 32'h0);

    // Straight-line fetch with 1-cycle memory.
    wait_pops(8, 40, "stream_start");

    // Decode stalled: only DEPTH fetches may be issued.
    instr_ready = 1'b0;
    redirect(32'h40);
    base = req_fires;
    repeat (10) tick();
    chk("stall_req_count", req_fires - base, DEPTH);
    chk("stall_req_valid", imem_req_valid, 0);
    instr_ready = 1'b1;
    wait_pops(DEPTH, 10, "stall_drain");
    chk("stall_last_pc", last_pc, 32'h44);

    // Redirect with two responses in flight.
    lat = 3;
    instr_ready = 1'b0;
    redirect(32'h80);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mq_addr.size() == 2 && !imem_rsp_valid) found = 1'b1;
      else tick();
    end
    chk("two_outstanding", found, 1);
    instr_ready = 1'b1;
    redirect(32'h100);
    wait_pops(1, 30, "redir_resume");
    chk("redir_first_pc", last_pc, 32'h100);

    // Redirect coinciding with a response and a pop.
    lat = 1;
    wait_pops(2, 20, "pre_same_cycle");
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (imem_rsp_valid && instr_valid) found = 1'b1;
      else tick();
    end
    chk("same_cycle_found", found, 1);
    redirect(32'h300);
    wait_pops(1, 20, "same_cycle_resume");
    chk("same_cycle_pc", last_pc, 32'h300);

`ifdef FETCH_MISALIGN_EN
    redirect(32'h102);
    chk("misalign_flag", fetch_misalign, 1);
    chk("misalign_pc", misalign_pc, 32'h102);
    any_req = 1'b0;
    repeat (8) begin
      any_req |= imem_req_valid;
      tick();
    end
    chk("halt_no_req", any_req, 0);
    chk("halt_no_instr", instr_valid, 0);
    redirect(32'h200);
    chk("misalign_clear", fetch_misalign, 0);
    wait_pops(1, 20, "halt_resume");
    chk("halt_resume_pc", last_pc, 32'h200);
`else
    any_req = 1'b0;
    redirect(32'h102);
    wait_pops(1, 20, "misalign_forced_pop");
    chk("misalign_forced_pc", last_pc, 32'h100);
    chk("misalign_any_req", any_req, 0);
`endif

    // Random memory latency, backpressure, decode stalls and redirects.
    lat = 3;
    rand_ready = 1'b1;
    for (int k = 0; k < 400; k++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
`ifdef FETCH_MISALIGN_EN
        redirect_pc = $urandom & 32'h0000_0FFC;
`else
        redirect_pc = $urandom & 32'h0000_0FFF;
`endif
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    rand_ready = 1'b0;
    instr_ready = 1'b1;
    wait_pops(4, 60, "final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
